// File: rtl/switch_port_arbiter_pkg.sv
// Shared definitions for the switch output-port arbiter.
package switch_pkg;

    localparam int DEF_N_PORTS = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef logic [$clog2(DEF_N_PORTS)-1:0] idx_t;

endpackage

// File: rtl/switch_port_arbiter_rr_picker.sv
// Rotating-priority encoder: first requester after i_ptr (wrapping) wins.
module rr_picker
    import switch_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int IDX_W   = $clog2(DEF_N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned cand;
        cand      = 0;
        o_any     = 1'b0;
        o_gnt_idx = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            cand = (32'(i_ptr) + k) % N_PORTS;
            if (!o_any && i_req[IDX_W'(cand)]) begin
                o_any     = 1'b1;
                o_gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/switch_port_arbiter.sv
// Packet-aware round-robin arbiter with registered output stage and stall watchdog.
module switch_port_arbiter
    import switch_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         req_valid,
    input  logic [DATA_W-1:0]          req_data [N_PORTS-1:0],
    input  logic [N_PORTS-1:0]         req_last,
    output logic [N_PORTS-1:0]         req_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(N_PORTS)-1:0] out_src,
    input  logic                       out_ready,
    output logic                       abort,
    output logic [$clog2(N_PORTS)-1:0] abort_src
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_gnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic [IDX_W-1:0]  r_out_src;
    logic              r_abort;
    logic [IDX_W-1:0]  r_abort_src;

    arb_state_e        w_state_nxt;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [IDX_W-1:0]  w_gnt_nxt;
    logic [CNT_W-1:0]  w_stall_nxt;
    logic [N_PORTS-1:0] w_ready;
    logic              w_accept;
    logic              w_abort_nxt;
    logic [IDX_W-1:0]  w_pick;
    logic              w_any;

    rr_picker #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_stall_nxt = r_stall_cnt;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_stall_nxt = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_ready[r_gnt] = !r_out_valid || out_ready;
                w_accept       = req_valid[r_gnt] && w_ready[r_gnt];
                if (w_accept) begin
                    w_stall_nxt = '0;
                    if (req_last[r_gnt]) begin
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = IDLE;
                    end
                end else if (!req_valid[r_gnt]) begin
                    // Counter holds stalls already seen; this cycle is the TIMEOUT-th.
                    if (r_stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_abort_nxt = 1'b1;
                        w_stall_nxt = '0;
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = IDLE;
                    end else begin
                        w_stall_nxt = r_stall_cnt + CNT_W'(1);
                    end
                end else begin
                    w_stall_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(N_PORTS - 1);
            r_gnt       <= '0;
            r_stall_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
            r_abort     <= 1'b0;
            r_abort_src <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_abort     <= w_abort_nxt;
            if (w_abort_nxt) begin
                r_abort_src <= r_gnt;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data[r_gnt];
                r_out_last  <= req_last[r_gnt];
                r_out_src   <= r_gnt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign abort     = r_abort;
    assign abort_src = r_abort_src;

endmodule
